// File: rtl/mips_pkg.sv
// mips_pkg -- shared types and helpers for the operand-forwarding scoreboard.
//   slot_t      : one scoreboard slot (an instruction downstream of ID)
//   FWD_SEL_RF  : operand-mux select meaning "take the register file value"
//   sel_w()     : width of an operand-mux select for a given forwarding depth
package mips_pkg;

  // Slot records are sized for the widest supported register address;
  // narrower register files zero-extend into rd. RA_W must not exceed this.
  localparam int RA_W_MAX   = 16;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RA_W_MAX-1:0] rd;
    logic                reg_write;
    logic                is_load;
  } slot_t;

  // Select codes run 0..depth, so depth+1 distinct values.
  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// fwd_match -- priority match of one source operand against the scoreboard.
//   slots_i    : scoreboard slots, index 0 = youngest (instruction in EX)
//   src_i      : source register address read by the ID instruction
//   use_i      : the ID instruction actually reads src_i
//   sel_o      : operand-mux select, 0 = register file, k = slot k-1
//   load_hit_o : the winning producer is a load whose data is not yet
//                available at its current position (needs a stall)
import mips_pkg::*;

module fwd_match #(
  parameter  int FWD_DEPTH = 2,
  parameter  int LOAD_SRC  = 2,
  parameter  int RA_W      = 5,
  localparam int SW        = sel_w(FWD_DEPTH)
) (
  input  slot_t [FWD_DEPTH-1:0] slots_i,
  input  logic  [RA_W-1:0]      src_i,
  input  logic                  use_i,
  output logic  [SW-1:0]        sel_o,
  output logic                  load_hit_o
);

  logic [FWD_DEPTH-1:0] hit;

  // r0 is hardwired to zero, so a write to it is never a real producer.
  for (genvar j = 0; j < FWD_DEPTH; j++) begin : g_hit
    assign hit[j] = slots_i[j].valid && slots_i[j].reg_write &&
                    (slots_i[j].rd == RA_W_MAX'(src_i)) && (src_i != '0);
  end

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel_o      = SW'(FWD_SEL_RF);
    load_hit_o = 1'b0;
    for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
      if (use_i && hit[j]) begin
        sel_o      = SW'(j + 1);
        load_hit_o = slots_i[j].is_load && ((j + 1) < LOAD_SRC);
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// forward_scoreboard -- tracks the last FWD_DEPTH issued instructions and
// produces EX operand-forwarding selects plus a load-use stall.
//   clk, rst          : clock, synchronous active-high reset
//   id_*              : decoded ID-stage instruction (valid, sources, dest,
//                       write enable, load flag)
//   flush             : kill the ID instruction this cycle (beats stall)
//   stall             : hold PC and IF/ID, bubble into EX (combinational)
//   ex_a_sel/ex_b_sel : registered operand-mux selects for the EX instruction
//   stall_count       : saturating count of stall cycles
import mips_pkg::*;

module forward_scoreboard #(
  parameter  int FWD_DEPTH = 2,
  parameter  int LOAD_SRC  = 2,
  parameter  int RA_W      = 5,
  localparam int SW        = sel_w(FWD_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic            flush,
  output logic            stall,
  output logic [SW-1:0]   ex_a_sel,
  output logic [SW-1:0]   ex_b_sel,
  output logic [15:0]     stall_count
);

  slot_t [FWD_DEPTH-1:0] slots_q, slots_d;
  logic  [SW-1:0]        a_sel_q, a_sel_d, b_sel_q, b_sel_d;
  logic  [15:0]          cnt_q, cnt_d;

  // Operand 0 = rs (A side), operand 1 = rt (B side).
  logic [1:0][RA_W-1:0] op_src;
  logic [1:0]           op_use;
  logic [1:0][SW-1:0]   op_sel;
  logic [1:0]           op_ld_hit;
  logic                 issue;

  assign op_src = {id_rt, id_rs};
  assign op_use = {id_use_rt, id_use_rs};

  for (genvar o = 0; o < 2; o++) begin : g_op
    fwd_match #(
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_SRC  (LOAD_SRC),
      .RA_W      (RA_W)
    ) u_match (
      .slots_i    (slots_q),
      .src_i      (op_src[o]),
      .use_i      (op_use[o]),
      .sel_o      (op_sel[o]),
      .load_hit_o (op_ld_hit[o])
    );
  end

  // The stall repeats naturally: the load ages one slot per cycle until its
  // data position reaches LOAD_SRC, at which point load_hit drops.
  assign stall = id_valid && !flush && (|op_ld_hit);
  assign issue = id_valid && !flush && !stall;

  always_comb begin
    slots_d = '0;
    for (int j = 1; j < FWD_DEPTH; j++) slots_d[j] = slots_q[j-1];
    if (issue) begin
      slots_d[0].valid     = 1'b1;
      slots_d[0].rd        = RA_W_MAX'(id_rd);
      slots_d[0].reg_write = id_reg_write;
      slots_d[0].is_load   = id_is_load;
    end
    a_sel_d = issue ? op_sel[0] : SW'(FWD_SEL_RF);
    b_sel_d = issue ? op_sel[1] : SW'(FWD_SEL_RF);
    cnt_d   = (stall && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q <= '0;
      a_sel_q <= SW'(FWD_SEL_RF);
      b_sel_q <= SW'(FWD_SEL_RF);
      cnt_q   <= '0;
    end else begin
      slots_q <= slots_d;
      a_sel_q <= a_sel_d;
      b_sel_q <= b_sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_a_sel    = a_sel_q;
  assign ex_b_sel    = b_sel_q;
  assign stall_count = cnt_q;

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 The block SHALL have parameter FWD_DEPTH, default 2, meaning the number of forwarding sources downstream of EX (1 = EX/MEM, 2 = MEM/WB, ...), legal range 1..4.
REQ-002 The block SHALL have parameter LOAD_SRC, default 2, meaning the lowest source index that can supply load data, legal range 1..FWD_DEPTH.
REQ-003 The block SHALL have parameter RA_W, default 5, meaning the register address width.
REQ-004 The block SHALL have the port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit, meaning the synchronous, active-high reset.
REQ-006 The block SHALL have the port id_valid, input, 1 bit, meaning the ID stage holds a real instruction.
REQ-007 The block SHALL have the ports id_rs and id_rt, input, RA_W bits each, meaning the ID source registers.
REQ-008 The block SHALL have the ports id_use_rs and id_use_rt, input, 1 bit each, meaning the ID instruction actually reads rs or rt.
REQ-009 The block SHALL have the port id_rd, input, RA_W bits, meaning the ID destination register.
REQ-010 The block SHALL have the port id_reg_write, input, 1 bit, meaning the ID instruction writes id_rd.
REQ-011 The block SHALL have the port id_is_load, input, 1 bit, meaning the ID instruction is a load.
REQ-012 The block SHALL have the port flush, input, 1 bit, meaning kill the ID instruction this cycle.
REQ-013 The block SHALL have the port stall, output, 1 bit, meaning hold PC and IF/ID and insert a bubble into EX.
REQ-014 The block SHALL have the ports ex_a_sel and ex_b_sel, output, SW = clog2(FWD_DEPTH+1) bits each, meaning the operand mux select for the instruction in EX: 0 = register file, k = source k.
REQ-015 The block SHALL have the port stall_count, output, 16 bits, meaning the saturating count of stall cycles.

Function
REQ-016 The block SHALL keep FWD_DEPTH scoreboard slots, slot j = {valid, rd, reg_write, is_load}; slot 0 SHALL correspond to the instruction in EX.
REQ-017 A slot j SHALL match a source register r only when valid=1, reg_write=1, rd=r and r!=0.
REQ-018 The next select for an operand SHALL be j+1 for the smallest matching j, the youngest producer winning; it SHALL be 0 when there is no match or when the operand is unused.
REQ-019 stall SHALL be combinational and equal id_valid & !flush & (some used operand's smallest matching slot j has is_load=1 and j+1 < LOAD_SRC).
REQ-020 Each cycle the slots SHALL shift up by one (slot j -> j+1, with the oldest discarded) with no hold condition.
REQ-021 When stall=0 and flush=0, slot 0 SHALL load {id_valid, id_rd, id_reg_write, id_is_load}, and ex_a_sel/ex_b_sel SHALL register the REQ-018 values (one-cycle latency from ID to EX).
REQ-022 When stall=1 or flush=1, slot 0 SHALL load a bubble (valid=0) and ex_a_sel/ex_b_sel SHALL register 0.
REQ-023 flush SHALL take priority over stall, so stall SHALL be 0 whenever flush=1.
REQ-024 A stall SHALL repeat each cycle until the load reaches slot LOAD_SRC-1, giving at most LOAD_SRC-1 consecutive stall cycles per hazard.
REQ-025 stall_count SHALL increment on each cycle with stall=1 and SHALL saturate at 16'hFFFF.
REQ-026 When id_valid=0, stall SHALL be 0 and a bubble SHALL enter slot 0.

Reset
REQ-027 While rst=1, all slot valids SHALL be 0, ex_a_sel=0, ex_b_sel=0 and stall_count=0; stall SHALL be 0 in the following cycle.
REQ-028 A reset asserted mid-stall SHALL discard all in-flight entries, and no stall SHALL occur after reset until a new load is tracked.

Structure
REQ-029 The slot record struct, the FWD_SEL_RF=0 constant and the SW width function SHALL live in the shared package mips_pkg.
REQ-030 A sub-module fwd_match SHALL perform the per-operand priority match (slots in, select plus load-hit out) and SHALL be instantiated twice, once for rs and once for rt.

Verification
REQ-031 The bench SHALL cover: add r3 (reg_write, rd=3), then sub reading rs=3 next cycle -> ex_a_sel=1 in the following cycle and stall=0.
REQ-032 The bench SHALL cover: lw rd=8, then add reading rt=8 -> stall=1 for exactly 1 cycle, then ex_b_sel=2, and stall_count=1.
REQ-033 The bench SHALL cover: add rd=4, add rd=4, then an instruction reading rs=4 -> ex_a_sel=1 (youngest producer wins).
REQ-034 The bench SHALL cover: a writer with rd=0, then a reader of r0 -> both selects 0 and no stall.
REQ-035 The bench SHALL cover: lw rd=5, then a reader of r5 with flush=1 in the same cycle -> stall=0, a bubble enters slot 0, and stall_count is unchanged.
REQ-036 The bench SHALL cover: FWD_DEPTH=3, LOAD_SRC=3, lw rd=6 then a reader of r6 -> 2 stall cycles followed by sel=3, and rst asserted during the second stall -> stall=0 the next cycle.
